// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath stages.
//   MW   : mantissa width (two's complement)
//   EW   : exponent width (two's complement)
//   SUMW : width of the raw aligned sum (one guard bit above MW)
//   SHW  : width of an alignment shift amount (covers 0..SUMW)
// Helpers:
//   sext17    : sign-extend an MW-bit mantissa to SUMW bits
//   min_shamt : |exponent difference| clamped to SUMW
package fp_pkg;

   localparam int MW   = 16;
   localparam int EW   = 8;
   localparam int SUMW = MW + 1;
   localparam int SHW  = 5;

   function automatic logic [SUMW-1:0] sext17(input logic [MW-1:0] m);
      return {m[MW-1], m};
   endfunction

   // Anything at or beyond SUMW shifts the operand out completely, so the
   // amount saturates there and never needs more than SHW bits.
   function automatic logic [SHW-1:0] min_shamt(input logic [EW:0] d);
      logic [EW:0] mag;
      mag = d[EW] ? -d : d;
      if (mag >= (EW+1)'(SUMW)) begin
         return SHW'(SUMW);
      end
      return mag[SHW-1:0];
   endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational alignment shifter.
//   small_m_i : SUMW-bit two's-complement operand to be aligned
//   shamt_i   : right-shift amount, 0..SUMW
//   aligned_o : small_m_i arithmetic-shifted right; 0 once shamt_i >= SUMW
//   round_o   : last bit shifted out (bit shamt_i-1), 0 when nothing shifted
//               out or the operand was discarded entirely
module fp_align_shift
   import fp_pkg::*;
(
   input  logic [SUMW-1:0] small_m_i,
   input  logic [SHW-1:0]  shamt_i,
   output logic [SUMW-1:0] aligned_o,
   output logic            round_o
);

   logic signed [SUMW-1:0] shifted;

   assign shifted = $signed(small_m_i) >>> shamt_i;

   // A fully shifted-out operand contributes nothing, not the sign fill.
   always_comb begin
      aligned_o = '0;
      round_o   = 1'b0;
      if (shamt_i < SHW'(SUMW)) begin
         aligned_o = shifted;
         if (shamt_i != '0) begin
            round_o = small_m_i[shamt_i - SHW'(1)];
         end
      end
   end

endmodule

// File: rtl/fp_add_align.sv
// Align/add stage of the FP adder, feeding ma/ea of fp_add_justify.
// Two pipeline registers with valid/ready on both sides, latency 2.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand-pair handshake
//   ma_a, ea_a        : operand A mantissa / exponent (two's complement)
//   ma_b, ea_b        : operand B mantissa / exponent
//   sub               : 1 = A - B, 0 = A + B
//   out_valid/out_ready : result handshake
//   ma_sum            : raw SUMW-bit sum, not normalized
//   ea_sum            : exponent of the sum (larger input exponent)
// ROUND = 1 adds the last shifted-out bit (round half-up); 0 truncates.
module fp_add_align
   import fp_pkg::*;
#(
   parameter int ROUND = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [MW-1:0]   ma_a,
   input  logic [EW-1:0]   ea_a,
   input  logic [MW-1:0]   ma_b,
   input  logic [EW-1:0]   ea_b,
   input  logic            sub,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SUMW-1:0] ma_sum,
   output logic [EW-1:0]   ea_sum
);

   logic            s1_valid_q;
   logic [SUMW-1:0] big_m_q, big_m_d;
   logic [EW-1:0]   big_e_q, big_e_d;
   logic [SUMW-1:0] small_m_q, small_m_d;
   logic [SHW-1:0]  shamt_q, shamt_d;
   logic            out_valid_q;
   logic [SUMW-1:0] ma_sum_q, ma_sum_d;
   logic [EW-1:0]   ea_sum_q;

   logic            s1_adv, s1_load;
   logic [SUMW-1:0] am, bm, aligned, rnd_add;
   logic [EW:0]     d;
   logic            a_zero, b_zero, round_bit;

   assign s1_adv   = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_adv;
   assign s1_load  = in_valid && in_ready;

   // Operand ordering. A zero mantissa is always the small operand so its
   // (meaningless) exponent never wins; exponent tie keeps A as big.
   always_comb begin
      am        = sext17(ma_a);
      bm        = sub ? -sext17(ma_b) : sext17(ma_b);
      d         = {ea_a[EW-1], ea_a} - {ea_b[EW-1], ea_b};
      a_zero    = (ma_a == '0);
      b_zero    = (ma_b == '0);
      big_m_d   = '0;
      big_e_d   = '0;
      small_m_d = '0;
      shamt_d   = '0;
      if (a_zero && b_zero) begin
         big_e_d = '0;
      end else if (b_zero) begin
         big_m_d = am;
         big_e_d = ea_a;
      end else if (a_zero) begin
         big_m_d = bm;
         big_e_d = ea_b;
      end else if (!d[EW]) begin
         big_m_d   = am;
         big_e_d   = ea_a;
         small_m_d = bm;
         shamt_d   = min_shamt(d);
      end else begin
         big_m_d   = bm;
         big_e_d   = ea_b;
         small_m_d = am;
         shamt_d   = min_shamt(d);
      end
   end

   fp_align_shift u_shift (
      .small_m_i (small_m_q),
      .shamt_i   (shamt_q),
      .aligned_o (aligned),
      .round_o   (round_bit)
   );

   assign rnd_add  = (ROUND != 0) ? {{(SUMW-1){1'b0}}, round_bit} : '0;
   assign ma_sum_d = big_m_q + aligned + rnd_add;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         big_m_q     <= '0;
         big_e_q     <= '0;
         small_m_q   <= '0;
         shamt_q     <= '0;
         out_valid_q <= 1'b0;
         ma_sum_q    <= '0;
         ea_sum_q    <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
         end
         if (s1_load) begin
            big_m_q   <= big_m_d;
            big_e_q   <= big_e_d;
            small_m_q <= small_m_d;
            shamt_q   <= shamt_d;
         end
         // Output registers only change when the downstream slot frees up,
         // which keeps them stable throughout a stall.
         if (s1_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               ma_sum_q <= ma_sum_d;
               ea_sum_q <= big_e_q;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign ma_sum    = ma_sum_q;
   assign ea_sum    = ea_sum_q;

endmodule

// File: tb/tb_fp_add_align.sv
module tb_fp_add_align;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, sub, out_ready;
   logic [15:0] ma_a, ma_b;
   logic [7:0]  ea_a, ea_b;
   logic        in_ready1, out_valid1, in_ready0, out_valid0;
   logic [16:0] ma_sum1, ma_sum0;
   logic [7:0]  ea_sum1, ea_sum0;

   fp_add_align #(.ROUND(1)) dut_r1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .ma_a(ma_a), .ea_a(ea_a), .ma_b(ma_b), .ea_b(ea_b), .sub(sub),
      .out_valid(out_valid1), .out_ready(out_ready),
      .ma_sum(ma_sum1), .ea_sum(ea_sum1)
   );

   fp_add_align #(.ROUND(0)) dut_r0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .ma_a(ma_a), .ea_a(ea_a), .ma_b(ma_b), .ea_b(ea_b), .sub(sub),
      .out_valid(out_valid0), .out_ready(out_ready),
      .ma_sum(ma_sum0), .ea_sum(ea_sum0)
   );

   typedef struct {
      logic [16:0] s1;
      logic [16:0] s0;
      logic [7:0]  e;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic        stalled  = 1'b0;
   logic [16:0] snap_s;
   logic [7:0]  snap_e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   // Reference: real-valued alignment as floor(small / 2^d), half-up on the
   // remainder, zero operands yield the other operand unchanged.
   function automatic void model(input logic [15:0] a, input logic [7:0] ea,
                                 input logic [15:0] b, input logic [7:0] eb,
                                 input logic s, input int rnd,
                                 output logic [16:0] sum, output logic [7:0] e);
      int av, bv, ae, be, bigv, bige, smv, dd, p, q, r;
      av = int'($signed(a));
      bv = int'($signed(b));
      if (s) bv = -bv;
      ae = int'($signed(ea));
      be = int'($signed(eb));
      if (a == 16'h0 && b == 16'h0) begin
         bigv = 0; bige = 0; smv = 0; dd = 100;
      end else if (b == 16'h0) begin
         bigv = av; bige = ae; smv = 0; dd = 100;
      end else if (a == 16'h0) begin
         bigv = bv; bige = be; smv = 0; dd = 100;
      end else if (ae >= be) begin
         bigv = av; bige = ae; smv = bv; dd = ae - be;
      end else begin
         bigv = bv; bige = be; smv = av; dd = be - ae;
      end
      if (dd >= 17) begin
         q = 0;
      end else begin
         p = 1 << dd;
         q = smv / p;
         if ((smv % p) != 0 && smv < 0) q = q - 1;
         r = smv - q * p;
         if (rnd != 0 && dd >= 1 && 2 * r >= p) q = q + 1;
      end
      sum = 17'(bigv + q);
      e   = 8'(bige);
   endfunction

   task automatic cycle(input logic iv, input logic [15:0] a, input logic [7:0] ea,
                        input logic [15:0] b, input logic [7:0] eb, input logic s,
                        input logic ordy, output logic acc, output logic got);
      exp_t        x;
      logic [7:0]  e0;
      @(negedge clk);
      in_valid  = iv;
      ma_a      = a;
      ea_a      = ea;
      ma_b      = b;
      ea_b      = eb;
      sub       = s;
      out_ready = ordy;
      #1;
      // Two entries in flight means both stages are occupied.
      chk("in_ready_r1", in_ready1, !(sb.size() == 2 && !ordy));
      chk("in_ready_r0", in_ready0, !(sb.size() == 2 && !ordy));
      acc = in_valid && in_ready1;
      got = out_valid1 && out_ready;
      if (got) begin
         if (sb.size() == 0) begin
            chk("spurious_out", out_valid1, 1'b0);
         end else begin
            x = sb.pop_front();
            chk("ma_sum_r1", ma_sum1, x.s1);
            chk("ma_sum_r0", ma_sum0, x.s0);
            chk("ea_sum_r1", ea_sum1, x.e);
            chk("ea_sum_r0", ea_sum0, x.e);
            chk("out_valid_r0", out_valid0, 1'b1);
         end
      end
      if (out_valid1 && !out_ready) begin
         if (stalled) begin
            chk("stall_ma_sum", ma_sum1, snap_s);
            chk("stall_ea_sum", ea_sum1, snap_e);
         end
         stalled = 1'b1;
         snap_s  = ma_sum1;
         snap_e  = ea_sum1;
      end else begin
         stalled = 1'b0;
      end
      if (acc) begin
         model(a, ea, b, eb, s, 1, x.s1, x.e);
         model(a, ea, b, eb, s, 0, x.s0, e0);
         sb.push_back(x);
      end
   endtask

   task automatic dir(input string tag, input logic [15:0] a, input logic [7:0] ea,
                      input logic [15:0] b, input logic [7:0] eb, input logic s,
                      input logic [16:0] exp1, input logic [16:0] exp0, input logic [7:0] expe);
      logic acc, got;
      int   lat;
      cycle(1'b1, a, ea, b, eb, s, 1'b1, acc, got);
      chk({tag, "_accept"}, acc, 1'b1);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
         cycle(1'b0, 16'h0, 8'h0, 16'h0, 8'h0, 1'b0, 1'b1, acc, got);
         lat++;
      end
      chk({tag, "_latency"}, lat, 2);
      chk({tag, "_ma_r1"}, ma_sum1, exp1);
      chk({tag, "_ma_r0"}, ma_sum0, exp0);
      chk({tag, "_ea"}, ea_sum1, expe);
   endtask

   initial begin
      logic        acc, got, pending, rv, ro, rs;
      logic [15:0] ra, rb;
      logic [7:0]  rea, reb;
      int          nacc, nout;

      rst = 1'b1; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1;
      ma_a = '0; ma_b = '0; ea_a = '0; ea_b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", in_ready1, 1'b1);
      chk("reset_out_valid", out_valid1, 1'b0);
      chk("reset_ma_sum", ma_sum1, 17'h0);
      chk("reset_ea_sum", ea_sum1, 8'h0);

      dir("t1_add",     16'h4000, 8'h00, 16'h4000, 8'h00, 1'b0, 17'h08000, 17'h08000, 8'h00);
      dir("t2_shift2",  16'h4000, 8'h02, 16'h4000, 8'h00, 1'b0, 17'h05000, 17'h05000, 8'h02);
      dir("t3_round",   16'h4000, 8'h01, 16'h4001, 8'h00, 1'b0, 17'h06001, 17'h06000, 8'h01);
      dir("t4_subeq",   16'h4000, 8'h03, 16'h4000, 8'h03, 1'b1, 17'h00000, 17'h00000, 8'h03);
      dir("t4_negmin",  16'h8000, 8'h00, 16'h8000, 8'h00, 1'b1, 17'h00000, 17'h00000, 8'h00);
      dir("t4_d255",    16'h4000, 8'h7F, 16'h4000, 8'h80, 1'b0, 17'h04000, 17'h04000, 8'h7F);
      dir("t4_azero",   16'h0000, 8'h00, 16'h8000, 8'hFB, 1'b0, 17'h18000, 17'h18000, 8'hFB);
      dir("both_zero",  16'h0000, 8'h12, 16'h0000, 8'h34, 1'b1, 17'h00000, 17'h00000, 8'h00);
      dir("shift17",    16'h7FFF, 8'h11, 16'h8000, 8'h00, 1'b0, 17'h07FFF, 17'h07FFF, 8'h11);
      dir("shift16",    16'h0001, 8'h10, 16'h8000, 8'h00, 1'b1, 17'h00002, 17'h00001, 8'h10);

      // Backpressure: third pair must be refused until the result side moves.
      nacc = 0;
      cycle(1'b1, 16'h1234, 8'h02, 16'h0F00, 8'h00, 1'b0, 1'b0, acc, got); if (acc) nacc++;
      cycle(1'b1, 16'h2000, 8'hFE, 16'h3000, 8'h01, 1'b1, 1'b0, acc, got); if (acc) nacc++;
      cycle(1'b1, 16'hC000, 8'h05, 16'h0101, 8'h03, 1'b0, 1'b0, acc, got); if (acc) nacc++;
      chk("bp_in_ready_low", in_ready1, 1'b0);
      repeat (3) begin
         cycle(1'b1, 16'hC000, 8'h05, 16'h0101, 8'h03, 1'b0, 1'b0, acc, got);
         if (acc) nacc++;
      end
      chk("bp_accepts", nacc, 2);
      pending = 1'b1;
      nout    = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(pending, 16'hC000, 8'h05, 16'h0101, 8'h03, 1'b0, 1'b1, acc, got);
         if (acc) pending = 1'b0;
         if (got) nout++;
      end
      chk("bp_results", nout, 3);
      chk("bp_sb_empty", sb.size(), 0);

      // Reset with both stages full.
      cycle(1'b1, 16'h1111, 8'h01, 16'h2222, 8'h02, 1'b0, 1'b0, acc, got);
      cycle(1'b1, 16'h3333, 8'h03, 16'h4444, 8'h04, 1'b1, 1'b0, acc, got);
      @(negedge clk);
      #1;
      chk("prerst_out_valid", out_valid1, 1'b1);
      chk("prerst_in_ready", in_ready1, 1'b0);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid1, 1'b0);
      chk("rst_in_ready", in_ready1, 1'b1);
      chk("rst_ma_sum", ma_sum1, 17'h0);
      sb.delete();
      stalled = 1'b0;
      dir("post_rst", 16'h4000, 8'h00, 16'h4000, 8'h00, 1'b0, 17'h08000, 17'h08000, 8'h00);
      chk("post_rst_sb_empty", sb.size(), 0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 9))
            0: ra = 16'h0;
            1: rb = 16'h0;
            2: ra = 16'h8000;
            3: rb = 16'h8000;
            default: ;
         endcase
         if ($urandom_range(0, 1) == 0) begin
            rea = 8'($urandom);
            reb = 8'($urandom);
         end else begin
            rea = 8'($urandom_range(0, 40)) - 8'd20;
            reb = 8'($urandom_range(0, 40)) - 8'd20;
         end
         rv = ($urandom_range(0, 9) < 7);
         ro = ($urandom_range(0, 9) < 7);
         rs = 1'($urandom_range(0, 1));
         cycle(rv, ra, rea, rb, reb, rs, ro, acc, got);
      end
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 16'h0, 8'h0, 16'h0, 8'h0, 1'b0, 1'b1, acc, got);
      end
      chk("drain_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
